mul_seq: RTL and testbench

Multi-cycle unsigned 32×32 shift-add multiplier that drives the shared combinational ALU as its initiator. It sequences ADD, SLL and SRL commands into the ALU and consumes each result. It returns the low 32 bits of the product plus an exact unsigned-overflow flag over a valid/ready handshake. It sits beside the execute stage and borrows the ALU port while busy; the execute stage muxes this block's ALU request onto the ALU whenever `busy` is high.

---
 rtl/mul_seq_if.sv | 43 ++++
 rtl/mul_seq.sv | 132 +++++++++++++
 tb/tb_mul_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_if.sv
// Shared ALU command/operand types and the bundle of operand, result and ALU
// signals that connects mul_seq to the execute stage.
package ALUType;
    typedef logic [31:0] op_t;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        XOR  = 4'd4,
        SLL  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        SLT  = 4'd8,
        SLTU = 4'd9
    } alu_cmd_t;
endpackage

interface mul_seq_if;
    logic               in_valid;
    logic               in_ready;
    ALUType::op_t       a;
    ALUType::op_t       b;
    logic               out_valid;
    logic               out_ready;
    ALUType::op_t       result;
    logic               ovf;
    ALUType::alu_cmd_t  alu_cmd;
    logic [31:0]        alu_a;
    logic [31:0]        alu_b;
    logic [31:0]        alu_out;

    modport slave (
        input  in_valid, a, b, out_ready, alu_out,
        output in_ready, out_valid, result, ovf, alu_cmd, alu_a, alu_b
    );

    modport master (
        output in_valid, a, b, out_ready, alu_out,
        input  in_ready, out_valid, result, ovf, alu_cmd, alu_a, alu_b
    );
endinterface

// File: rtl/mul_seq.sv
// Sequential 32x32 unsigned shift-add multiplier that borrows the shared
// combinational ALU for every add and shift; reports low product and overflow.
module mul_seq (
    input  logic       clk,
    input  logic       rst,
    mul_seq_if.slave   bus,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ADD   = 3'd2,
        SHL   = 3'd3,
        SHR   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t       state_r;
    logic [31:0]  acc_r;
    logic [31:0]  mc_r;
    logic [31:0]  mp_r;
    logic         lost_r;
    logic         ovf_r;

    // Unsigned carry-out of x+y recovered from the operand and sum MSBs only.
    function automatic logic carry_out(input logic [31:0] x,
                                       input logic [31:0] y,
                                       input logic [31:0] sum);
        return (x[31] & y[31]) | ((x[31] | y[31]) & ~sum[31]);
    endfunction

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            acc_r   <= 32'd0;
            mc_r    <= 32'd0;
            mp_r    <= 32'd0;
            lost_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        mc_r    <= bus.a;
                        mp_r    <= bus.b;
                        acc_r   <= 32'd0;
                        lost_r  <= 1'b0;
                        ovf_r   <= 1'b0;
                        state_r <= CHECK;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CHECK: begin
                    if (mp_r == 32'd0) begin
                        state_r <= DONE;
                    end else if (mp_r[0]) begin
                        state_r <= ADD;
                    end else begin
                        state_r <= SHL;
                    end
                end
                ADD: begin
                    // A multiplicand bit already shifted out means this add
                    // contributes at or above 2^32.
                    acc_r   <= bus.alu_out;
                    ovf_r   <= ovf_r | carry_out(acc_r, mc_r, bus.alu_out) | lost_r;
                    state_r <= SHL;
                end
                SHL: begin
                    mc_r    <= bus.alu_out;
                    lost_r  <= lost_r | mc_r[31];
                    state_r <= SHR;
                end
                SHR: begin
                    mp_r    <= bus.alu_out;
                    state_r <= CHECK;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.result    = acc_r;
    assign bus.ovf       = ovf_r;
    assign bus.out_valid = (state_r == DONE);

    // Handshake status and ALU request decoded from the current state.
    always_comb begin
        bus.in_ready = 1'b0;
        busy         = 1'b1;
        bus.alu_cmd  = ALUType::AND;
        bus.alu_a    = 32'd0;
        bus.alu_b    = 32'd0;
        case (state_r)
            IDLE: begin
                bus.in_ready = 1'b1;
                busy         = 1'b0;
            end
            ADD: begin
                bus.alu_cmd = ALUType::ADD;
                bus.alu_a   = acc_r;
                bus.alu_b   = mc_r;
            end
            SHL: begin
                bus.alu_cmd = ALUType::SLL;
                bus.alu_a   = mc_r;
                bus.alu_b   = 32'd1;
            end
            SHR: begin
                bus.alu_cmd = ALUType::SRL;
                bus.alu_a   = mp_r;
                bus.alu_b   = 32'd1;
            end
            default: begin
                bus.alu_cmd = ALUType::AND;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: product/overflow/latency model checked every
// cycle, directed literal cases, and randomized operands with backpressure.
module tb_mul_seq;

    logic clk;
    logic rst;
    logic busy;

    mul_seq_if bif ();

    mul_seq dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bif),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU stand-in for the execute-stage ALU.
    always_comb begin
        case (bif.alu_cmd)
            ALUType::ADD: bif.alu_out = bif.alu_a + bif.alu_b;
            ALUType::AND: bif.alu_out = bif.alu_a & bif.alu_b;
            ALUType::SLL: bif.alu_out = bif.alu_a << bif.alu_b[4:0];
            ALUType::SRL: bif.alu_out = bif.alu_a >> bif.alu_b[4:0];
            default:      bif.alu_out = 32'd0;
        endcase
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_latency(input logic [31:0] b);
        int k = 0;
        for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
        return 2 + 3 * k + $countones(b);
    endfunction

    // Reference: full 64-bit product decides both the result and the overflow.
    typedef struct packed {
        logic [31:0] res;
        logic        ov;
        logic [31:0] due;
    } exp_t;

    exp_t               q[$];
    int                 cyc = 0;
    logic               model_on = 1'b0;
    logic               pending;
    logic               exp_ov;
    logic [63:0]        prod;
    logic               tracing = 1'b0;
    ALUType::alu_cmd_t  trace[$];

    // Model compare: every cycle, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (model_on) begin
            pending = (q.size() > 0);
            check("in_ready", {63'd0, bif.in_ready}, {63'd0, !pending});
            check("busy", {63'd0, busy}, {63'd0, pending});
            exp_ov = 1'b0;
            if (pending) exp_ov = (cyc >= int'(q[0].due));
            check("out_valid", {63'd0, bif.out_valid}, {63'd0, exp_ov});
            if (bif.out_valid && pending) begin
                check("result", {32'd0, bif.result}, {32'd0, q[0].res});
                check("ovf", {63'd0, bif.ovf}, {63'd0, q[0].ov});
            end
            if (bif.alu_cmd == ALUType::AND) begin
                check("alu_idle_a", {32'd0, bif.alu_a}, 64'd0);
                check("alu_idle_b", {32'd0, bif.alu_b}, 64'd0);
            end else if (bif.alu_cmd == ALUType::SLL || bif.alu_cmd == ALUType::SRL) begin
                check("alu_shift_b", {32'd0, bif.alu_b}, 64'd1);
            end
            if (tracing && bif.alu_cmd != ALUType::AND) trace.push_back(bif.alu_cmd);

            if (rst) begin
                q.delete();
            end else begin
                if (pending && bif.out_valid && bif.out_ready) void'(q.pop_front());
                if (!pending && bif.in_valid) begin
                    prod = {32'd0, bif.a} * {32'd0, bif.b};
                    q.push_back('{res: prod[31:0], ov: (prod[63:32] != 32'd0),
                                  due: 32'(cyc + exp_latency(bif.b))});
                end
            end
        end
    end

    task automatic send(input logic [31:0] av, input logic [31:0] bv);
        int n = 0;
        @(posedge clk); #1;
        bif.in_valid = 1'b1;
        bif.a = av;
        bif.b = bv;
        do begin
            @(negedge clk);
            n++;
        end while (!bif.in_ready && n < 300);
        if (!bif.in_ready) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bif.out_valid && lat < 300);
        if (!bif.out_valid) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_lit(input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] er, input logic eo, input int el);
        int lat;
        send(av, bv);
        wait_done(lat);
        check("lit_latency", 64'(lat), 64'(el));
        check("lit_result", {32'd0, bif.result}, {32'd0, er});
        check("lit_ovf", {63'd0, bif.ovf}, {63'd0, eo});
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ALUType::alu_cmd_t exp_trace[8];
        logic [31:0] av, bv;
        int lat, n;

        rst = 1'b1;
        bif.in_valid = 1'b0;
        bif.a = 32'd0;
        bif.b = 32'd0;
        bif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {63'd0, bif.in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, bif.out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_result", {32'd0, bif.result}, 64'd0);
        check("rst_ovf", {63'd0, bif.ovf}, 64'd0);
        check("rst_alu_cmd", 64'(bif.alu_cmd), 64'(ALUType::AND));
        check("rst_alu_a", {32'd0, bif.alu_a}, 64'd0);
        check("rst_alu_b", {32'd0, bif.alu_b}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_on = 1'b1;

        run_lit(32'd7, 32'd0, 32'd0, 1'b0, 2);

        trace.delete();
        tracing = 1'b1;
        run_lit(32'd3, 32'd5, 32'd15, 1'b0, 13);
        tracing = 1'b0;
        exp_trace = '{ALUType::ADD, ALUType::SLL, ALUType::SRL, ALUType::SLL,
                      ALUType::SRL, ALUType::ADD, ALUType::SLL, ALUType::SRL};
        check("trace_len", 64'(trace.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < trace.size()) check("trace_cmd", 64'(trace[i]), 64'(exp_trace[i]));
        end

        run_lit(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 54);
        run_lit(32'h8000_0000, 32'd3, 32'h8000_0000, 1'b1, 10);
        run_lit(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 6);
        run_lit(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b1, 130);

        // Hold the result in DONE and poke in_valid while it waits.
        bif.out_ready = 1'b0;
        send(32'h1234, 32'h56);
        wait_done(lat);
        check("hold_latency", 64'(lat), 64'd27);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bif.in_valid = (i == 3);
            bif.a = 32'd9;
            bif.b = 32'd9;
            @(negedge clk);
            check("hold_result", {32'd0, bif.result}, 64'h61D78);
            check("hold_ovf", {63'd0, bif.ovf}, 64'd0);
            check("hold_in_ready", {63'd0, bif.in_ready}, 64'd0);
        end
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_out_valid", {63'd0, bif.out_valid}, 64'd0);
        check("release_busy", {63'd0, busy}, 64'd0);

        // Abort during the first SHL of 3*5.
        send(32'd3, 32'd5);
        @(posedge clk);
        @(posedge clk); #1;
        check("abort_in_shl", 64'(bif.alu_cmd), 64'(ALUType::SLL));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", {63'd0, bif.in_ready}, 64'd1);
        check("abort_out_valid", {63'd0, bif.out_valid}, 64'd0);
        repeat (20) @(posedge clk);
        #1;
        run_lit(32'd2, 32'd2, 32'd4, 1'b0, 9);

        // Random operands, random consumer backpressure, stray in_valid pulses.
        for (int t = 0; t < 40; t++) begin
            av = $urandom;
            n = $urandom_range(0, 32);
            bv = (n == 32) ? 32'd0 : ($urandom >> n);
            if (t % 8 == 0) av = 32'hFFFF_FFFF;
            send(av, bv);
            n = 0;
            do begin
                @(posedge clk); #1;
                bif.out_ready = 1'($urandom_range(0, 1));
                bif.in_valid = ($urandom_range(0, 3) == 0);
                bif.a = $urandom;
                bif.b = $urandom;
                @(negedge clk);
                n++;
            end while (!(bif.out_valid && bif.out_ready) && n < 600);
            if (!(bif.out_valid && bif.out_ready)) check("rand_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
            bif.in_valid = 1'b0;
            bif.out_ready = 1'b1;
        end

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
